// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg: shared defaults for the regfile_mp register file.
// Used unchanged whether or not REGFILE_BYPASS_EN is defined.
package ecap5_dproc_pkg;
    localparam int DEF_XLEN = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW = $clog2(DEF_NREGS);
    typedef logic [DEF_AW-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write counters with reserve/retire and underflow flag.
// REGFILE_BYPASS_EN adds multi_o (count > 1) so the top can report post-retire busy.
module regfile_scoreboard import ecap5_dproc_pkg::*; #(
    parameter int NREGS = DEF_NREGS,
    parameter int MAXPEND = 3,
    parameter int AW = $clog2(NREGS),
    parameter int PW = $clog2(MAXPEND + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rsv_i,
    input  logic [AW-1:0]    rsv_addr_i,
    input  logic             write_i,
    input  logic [AW-1:0]    waddr_i,
    output logic [NREGS-1:0] busy_o,
`ifdef REGFILE_BYPASS_EN
    output logic [NREGS-1:0] multi_o,
`endif
    output logic             full_o,
    output logic             underflow_o
);
    logic [PW-1:0] cnt_q [NREGS];
    logic [PW-1:0] cnt_d [NREGS];
    logic underflow_q, underflow_d;
    logic rsv_in, rsv_ok, wr_ok, same;
    assign rsv_in = rsv_addr_i != '0 && {1'b0, rsv_addr_i} < (AW+1)'(NREGS);
    assign rsv_ok = rsv_i && rsv_in;
    assign wr_ok = write_i && waddr_i != '0 && {1'b0, waddr_i} < (AW+1)'(NREGS);
    // A reserve and a retire on the same register cancel out
    assign same = rsv_ok && wr_ok && rsv_addr_i == waddr_i;
    assign full_o = rsv_in && cnt_q[rsv_addr_i] == PW'(MAXPEND);
    assign underflow_d = wr_ok && !same && cnt_q[waddr_i] == '0;
    assign underflow_o = underflow_q;
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!same && rsv_ok && rsv_addr_i == AW'(i) && cnt_q[i] != PW'(MAXPEND))
                cnt_d[i] = cnt_q[i] + 1'b1;
            if (!same && wr_ok && waddr_i == AW'(i) && cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            underflow_q <= underflow_d;
        end
    end
    for (genvar i = 0; i < NREGS; i++) begin : g_busy
        assign busy_o[i] = cnt_q[i] != '0;
`ifdef REGFILE_BYPASS_EN
        assign multi_o[i] = cnt_q[i] > PW'(1);
`endif
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with per-register write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp import ecap5_dproc_pkg::*; #(
    parameter int XLEN = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD = 2,
    parameter int MAXPEND = 3,
    localparam int AW = $clog2(NREGS),
    localparam int PW = $clog2(MAXPEND + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic                rsv_i,
    input  logic [AW-1:0]       rsv_addr_i,
    output logic                rsv_full_o,
    input  logic                write_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                underflow_o
);
    logic [XLEN-1:0] mem_q [NREGS];
    logic [NREGS-1:0] busy;
    logic wr_ok;
    assign wr_ok = write_i && waddr_i != '0 && {1'b0, waddr_i} < (AW+1)'(NREGS);
`ifdef REGFILE_BYPASS_EN
    logic [NREGS-1:0] multi;
`endif
    regfile_scoreboard #(.NREGS(NREGS), .MAXPEND(MAXPEND), .AW(AW), .PW(PW)) u_sb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rsv_i       (rsv_i),
        .rsv_addr_i  (rsv_addr_i),
        .write_i     (write_i),
        .waddr_i     (waddr_i),
        .busy_o      (busy),
`ifdef REGFILE_BYPASS_EN
        .multi_o     (multi),
`endif
        .full_o      (rsv_full_o),
        .underflow_o (underflow_o)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic in_rng, byp, nbusy;
        assign ra = raddr_i[k*AW +: AW];
        assign in_rng = ra != '0 && {1'b0, ra} < (AW+1)'(NREGS);
`ifdef REGFILE_BYPASS_EN
        // Busy reflects the count after this write retires, unless a reserve refills it
        assign byp = wr_ok && waddr_i == ra;
        assign nbusy = (rsv_i && rsv_addr_i == ra) ? busy[ra] : multi[ra];
`else
        assign byp = 1'b0;
        assign nbusy = 1'b0;
`endif
        assign rdata_o[k*XLEN +: XLEN] = !in_rng ? '0 : byp ? wdata_i : mem_q[ra];
        assign rbusy_o[k] = in_rng && (byp ? nbusy : busy[ra]);
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and randomized checks of regfile_mp against an array/counter model.
module tb_regfile_mp;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, MAXPEND = 3, AW = 5;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic [NRD*AW-1:0] raddr_i = '0;
    logic [NRD*XLEN-1:0] rdata_o;
    logic [NRD-1:0] rbusy_o;
    logic rsv_i = 1'b0, write_i = 1'b0;
    logic [AW-1:0] rsv_addr_i = '0, waddr_i = '0;
    logic [XLEN-1:0] wdata_i = '0;
    logic rsv_full_o, underflow_o;
    int vectors = 0, miscompares = 0;
    logic [XLEN-1:0] m_mem [NREGS];
    int m_cnt [NREGS];
    bit m_uf;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .MAXPEND(MAXPEND)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .rbusy_o(rbusy_o),
        .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i), .rsv_full_o(rsv_full_o), .write_i(write_i),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [XLEN-1:0] exp_rd(int k);
        logic [AW-1:0] a = raddr_i[k*AW +: AW];
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (write_i && waddr_i == a) return wdata_i;
`endif
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(int k);
        logic [AW-1:0] a = raddr_i[k*AW +: AW];
        if (a == '0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (write_i && waddr_i == a)
            return (rsv_i && rsv_addr_i == a) ? m_cnt[a] != 0 : m_cnt[a] > 1;
`endif
        return m_cnt[a] != 0;
    endfunction

    task automatic model_edge();
        bit r, w;
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_cnt[i] = 0; end
            m_uf = 1'b0;
            return;
        end
        r = rsv_i && rsv_addr_i != '0;
        w = write_i && waddr_i != '0;
        m_uf = w && m_cnt[waddr_i] == 0 && !(r && rsv_addr_i == waddr_i);
        if (w) m_mem[waddr_i] = wdata_i;
        if (!(r && w && rsv_addr_i == waddr_i)) begin
            if (r && m_cnt[rsv_addr_i] < MAXPEND) m_cnt[rsv_addr_i]++;
            if (w && m_cnt[waddr_i] > 0) m_cnt[waddr_i]--;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rsv_i = 1'b0;
        write_i = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        idle();
        for (int a = 0; a < NREGS; a++) begin
            raddr_i = {AW'(NREGS - 1 - a), AW'(a)};
            rsv_addr_i = AW'(a);
            #1;
            vectors++;
            if (rdata_o !== '0) begin miscompares++; $display("FAIL reset_rdata addr %0d got %h exp 0", a, rdata_o); end
            vectors++;
            if (rbusy_o !== '0) begin miscompares++; $display("FAIL reset_rbusy addr %0d got %b exp 00", a, rbusy_o); end
            vectors++;
            if (rsv_full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full addr %0d got %b exp 0", a, rsv_full_o); end
        end
        vectors++;
        if (underflow_o !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %b exp 0", underflow_o); end
    endtask

    task automatic test_write();
        write_i = 1'b1; waddr_i = 5; wdata_i = 32'hDEADBEEF;
        tick();
        idle();
        raddr_i = {AW'(0), AW'(5)};
        #1;
        vectors++;
        if (rdata_o[31:0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_x5 got %h exp deadbeef", rdata_o[31:0]); end
        vectors++;
        if (rdata_o[63:32] !== 32'h0) begin miscompares++; $display("FAIL read_x0 got %h exp 0", rdata_o[63:32]); end
        vectors++;
        if (underflow_o !== 1'b1) begin miscompares++; $display("FAIL write_x5_underflow got %b exp 1", underflow_o); end
        write_i = 1'b1; waddr_i = 0; wdata_i = 32'h1;
        tick();
        idle();
        raddr_i = {AW'(5), AW'(0)};
        #1;
        vectors++;
        if (rdata_o[31:0] !== 32'h0) begin miscompares++; $display("FAIL write_x0 got %h exp 0", rdata_o[31:0]); end
        vectors++;
        if (rdata_o[63:32] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL x5_port1 got %h exp deadbeef", rdata_o[63:32]); end
        vectors++;
        if (underflow_o !== 1'b0) begin miscompares++; $display("FAIL write_x0_underflow got %b exp 0", underflow_o); end
    endtask

    task automatic test_reserve();
        rsv_addr_i = 7;
        raddr_i = {AW'(0), AW'(7)};
        for (int i = 0; i < 3; i++) begin rsv_i = 1'b1; tick(); end
        idle();
        #1;
        vectors++;
        if (rsv_full_o !== 1'b1) begin miscompares++; $display("FAIL rsv_full got %b exp 1", rsv_full_o); end
        vectors++;
        if (rbusy_o[0] !== 1'b1) begin miscompares++; $display("FAIL rsv_busy got %b exp 1", rbusy_o[0]); end
        rsv_i = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            write_i = 1'b1; waddr_i = 7; wdata_i = 32'h100 + i;
            tick();
            idle();
            #1;
            vectors++;
            if (rbusy_o[0] !== (i < 2)) begin miscompares++; $display("FAIL retire_busy write %0d got %b exp %b", i, rbusy_o[0], i < 2); end
            vectors++;
            if (rsv_full_o !== 1'b0) begin miscompares++; $display("FAIL retire_full write %0d got %b exp 0", i, rsv_full_o); end
            vectors++;
            if (underflow_o !== (i == 3)) begin miscompares++; $display("FAIL retire_underflow write %0d got %b exp %b", i, underflow_o, i == 3); end
            vectors++;
            if (rdata_o[31:0] !== 32'h100 + i) begin miscompares++; $display("FAIL retire_data write %0d got %h exp %h", i, rdata_o[31:0], 32'h100 + i); end
        end
    endtask

    task automatic test_same_cycle();
        rsv_i = 1'b1; rsv_addr_i = 9;
        tick();
        write_i = 1'b1; waddr_i = 9; wdata_i = 32'hCAFE0009;
        tick();
        idle();
        raddr_i = {AW'(9), AW'(0)};
        #1;
        vectors++;
        if (rbusy_o[1] !== 1'b1) begin miscompares++; $display("FAIL same_busy got %b exp 1", rbusy_o[1]); end
        vectors++;
        if (rdata_o[63:32] !== 32'hCAFE0009) begin miscompares++; $display("FAIL same_data got %h exp cafe0009", rdata_o[63:32]); end
        vectors++;
        if (underflow_o !== 1'b0) begin miscompares++; $display("FAIL same_underflow got %b exp 0", underflow_o); end
        write_i = 1'b1; wdata_i = 32'h9;
        tick();
        idle();
        #1;
        vectors++;
        if (rbusy_o[1] !== 1'b0 || underflow_o !== 1'b0) begin miscompares++; $display("FAIL same_retire got busy %b uf %b exp 0 0", rbusy_o[1], underflow_o); end
    endtask

    task automatic test_underflow();
        write_i = 1'b1; waddr_i = 4; wdata_i = 32'h44444444;
        raddr_i = {AW'(0), AW'(4)};
        tick();
        idle();
        #1;
        vectors++;
        if (underflow_o !== 1'b1) begin miscompares++; $display("FAIL underflow_pulse got %b exp 1", underflow_o); end
        vectors++;
        if (rdata_o[31:0] !== 32'h44444444) begin miscompares++; $display("FAIL underflow_data got %h exp 44444444", rdata_o[31:0]); end
        tick();
        vectors++;
        if (underflow_o !== 1'b0) begin miscompares++; $display("FAIL underflow_clear got %b exp 0", underflow_o); end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] e;
`ifdef REGFILE_BYPASS_EN
        e = 32'h1234;
`else
        e = 32'h0;
`endif
        raddr_i = {AW'(0), AW'(3)};
        write_i = 1'b1; waddr_i = 3; wdata_i = 32'h1234;
        #1;
        vectors++;
        if (rdata_o[31:0] !== e) begin miscompares++; $display("FAIL bypass_same_cycle got %h exp %h", rdata_o[31:0], e); end
        vectors++;
        if (rbusy_o[0] !== 1'b0) begin miscompares++; $display("FAIL bypass_busy got %b exp 0", rbusy_o[0]); end
        tick();
        idle();
        #1;
        vectors++;
        if (rdata_o[31:0] !== 32'h1234) begin miscompares++; $display("FAIL bypass_next got %h exp 1234", rdata_o[31:0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rsv_i = $urandom_range(0, 2) == 0;
            write_i = $urandom_range(0, 2) == 0;
            rsv_addr_i = AW'($urandom_range(0, 7));
            waddr_i = AW'($urandom_range(0, 7));
            wdata_i = $urandom;
            raddr_i = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            #1;
            for (int k = 0; k < NRD; k++) begin
                vectors++;
                if (rdata_o[k*XLEN +: XLEN] !== exp_rd(k)) begin miscompares++; $display("FAIL rand_rdata cyc %0d port %0d got %h exp %h", n, k, rdata_o[k*XLEN +: XLEN], exp_rd(k)); end
                vectors++;
                if (rbusy_o[k] !== exp_busy(k)) begin miscompares++; $display("FAIL rand_rbusy cyc %0d port %0d got %b exp %b", n, k, rbusy_o[k], exp_busy(k)); end
            end
            vectors++;
            if (rsv_full_o !== (rsv_addr_i != 0 && m_cnt[rsv_addr_i] == MAXPEND)) begin miscompares++; $display("FAIL rand_full cyc %0d got %b", n, rsv_full_o); end
            vectors++;
            if (underflow_o !== m_uf) begin miscompares++; $display("FAIL rand_underflow cyc %0d got %b exp %b", n, underflow_o, m_uf); end
            tick();
        end
        idle();
    endtask

    task automatic test_midreset();
        rsv_i = 1'b1; rsv_addr_i = 7;
        tick();
        tick();
        write_i = 1'b1; waddr_i = 7; wdata_i = 32'h77777777; rst_i = 1'b1;
        tick();
        idle();
        for (int a = 0; a < NREGS; a++) begin
            raddr_i = {AW'(a), AW'(a)};
            rsv_addr_i = AW'(a);
            #1;
            vectors++;
            if (rdata_o !== '0 || rbusy_o !== '0 || rsv_full_o !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset addr %0d got data %h busy %b full %b exp 0", a, rdata_o, rbusy_o, rsv_full_o);
            end
        end
        vectors++;
        if (underflow_o !== 1'b0) begin miscompares++; $display("FAIL midreset_underflow got %b exp 0", underflow_o); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_reserve();
        test_same_cycle();
        test_underflow();
        test_bypass();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
